lut_search_arbiter: RTL and testbench
=====================================

// Module: lut_search_arbiter
// PURPOSE
//  Shares one piecewise-linear table ROM (COS or ASIN table) between NREQ lookup engines.
//  Round-robin grants one key at a time, then linearly scans the ROM from address 0.
//  Returns the bracketing pair (x0,y0),(x1,y1) for the requester's interpolation datapath.
//  Sits between the GPS distance datapath engines and the COS/ASIN table port.
// PARAMETERS
//  NREQ    2    number of requesters (1..4)
//  X_W     48   table X field width; ROM word bits [2*X_W-1:X_W]
//  Y_W     48   table Y field width; ROM word bits [Y_W-1:0]
//  ADDR_W  7    ROM address width
//  DEPTH   128  valid table entries, addresses 0..DEPTH-1, X strictly ascending
// PORTS
//  clk       in   1            clock
//  reset_n   in   1            asynchronous active-low reset
//  req       in   NREQ         per-requester lookup request, level, held until ack
//  key       in   NREQ*X_W     per-requester key, slice i = [i*X_W +: X_W], unsigned
//  ack       out  NREQ         one-cycle pulse: key of requester i latched
//  rom_addr  out  ADDR_W       registered ROM address
//  rom_data  in   X_W+Y_W      ROM word for the current rom_addr (combinational ROM)
//  rsp_valid out  1            one-cycle pulse, result fields valid
//  rsp_id    out  $clog2(NREQ) requester served (width min 1)
//  rsp_x0/rsp_y0 out X_W/Y_W   lower bracket entry
//  rsp_x1/rsp_y1 out X_W/Y_W   upper bracket entry
//  rsp_low   out  1            key < X[0]; both brackets = entry 0
//  rsp_oor   out  1            key >= X[DEPTH-1]; both brackets = entry DEPTH-1
// BEHAVIOUR
//  Reset: state IDLE, ack=0, rom_addr=0, rsp_*=0, RR pointer = requester 0 has priority.
//  FSM IDLE->SCAN->IDLE. No other states.
//  IDLE, any req: pick winner by round-robin from pointer; latch key and id; ack[id]<=1 for one
//   cycle; rom_addr<=0; pointer<=id+1 (mod NREQ); ->SCAN. No req: stay, ack=0.
//  SCAN, each cycle: compare key < rom_data.X (unsigned, strict).
//   hit at addr 0: rsp_low=1, x0,y0 = x1,y1 = entry 0.
//   hit at addr k>0: x1,y1 = entry k; x0,y0 = entry k-1 (held in prev register).
//   miss, addr<DEPTH-1: prev<=rom_data; rom_addr++.
//   miss, addr=DEPTH-1: rsp_oor=1, x0,y0 = x1,y1 = entry DEPTH-1; rom_addr never wraps.
//   On hit or terminal miss: rsp_* registered, rsp_valid<=1, ->IDLE.
//  key == X[k] counts as miss (bracket is k..k+1).
//  Latency: rsp_valid high k+1 cycles after ack for a hit at index k; DEPTH cycles worst case.
//  rsp_valid and rsp_* fields hold for exactly one cycle. rsp_valid clears the next cycle.
//   Fields then hold their values until the next response.
//  IDLE may grant a new request in the same cycle that rsp_valid is high (back-to-back).
//  req is ignored during SCAN. A requester must deassert req the cycle after its ack
//   unless it issues a new lookup.
//  Requests arriving simultaneously: exactly one ack per grant. The loser keeps req and is
//   granted next (starvation-free).
//  Reset mid-scan: lookup abandoned; no rsp_valid, no ack. Requester re-issues.
//  A NREQ=1 build has no pointer logic; rsp_id is tied to 0.
// STRUCTURE
//  gps_pkg: X_W/Y_W/ADDR_W defaults, Rad constant, field-extract macros for ROM words, and
//   the state encoding.
//  Sub-module rr_arbiter (NREQ): req vector + pointer -> one-hot grant and encoded id.
//  Top level: FSM, key/id latches, prev register, address counter, response registers.
// TESTING
//  Table X = 10*(i+1), Y = i; NREQ=2.
//  req0 key=35 -> ack0; rsp k=3: x0=30,y0=2,x1=40,y1=3; rsp_valid 4 cycles after ack.
//  req0 and req1 same cycle, keys 15/55 -> ack0 first, rsp id0, then ack1, rsp id1.
//   Repeat the pair: second round grants req1 first.
//  key=5 -> rsp_low=1, x0=x1=10, y0=y1=0, one cycle after ack.
//  key=1280 (>=X[127]) -> rsp_oor=1, brackets entry 127; 128 cycles; rom_addr stops at 127.
//  key=40 (exact) -> x0=40, x1=50 (strict compare).
//  reset_n low mid-scan -> all outputs 0 asynchronously; no rsp_valid; next req is served
//   normally.

Source files
------------

// File: rtl/lut_search_arbiter_pkg.sv
// Shared defaults and FSM encoding for the COS/ASIN table search arbiter.
// ROM word layout: X in the upper X_W bits, Y in the lower Y_W bits.
package lut_search_arbiter_pkg;

    localparam int X_W_DEF    = 48;
    localparam int Y_W_DEF    = 48;
    localparam int ADDR_W_DEF = 7;
    localparam int DEPTH_DEF  = 128;

    // Earth radius in metres, used by the distance datapath alongside these tables.
    localparam logic [47:0] RAD = 48'd6371000;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/lut_search_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr wins.
// Produces a one-hot grant and the encoded winner id.
module lut_search_arbiter_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id
);

    int  idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/lut_search_arbiter.sv
// Shares one piecewise-linear table ROM between NREQ lookup engines: grant one key,
// linearly scan from address 0, return the bracketing pair of entries.
module lut_search_arbiter
    import lut_search_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*X_W-1:0] key,
    output logic [NREQ-1:0]     ack,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [X_W+Y_W-1:0]  rom_data,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [X_W-1:0]      rsp_x0,
    output logic [Y_W-1:0]      rsp_y0,
    output logic [X_W-1:0]      rsp_x1,
    output logic [Y_W-1:0]      rsp_y1,
    output logic                rsp_low,
    output logic                rsp_oor
);

    state_e              state_q, state_d;
    logic [X_W-1:0]      key_q;
    logic [ID_W-1:0]     id_q, ptr_q, win_id;
    logic [NREQ-1:0]     grant;
    logic [X_W+Y_W-1:0]  prev_q;
    logic [X_W-1:0]      rom_x;
    logic [Y_W-1:0]      rom_y;
    logic                start, hit, last, done;

    assign rom_x = rom_data[Y_W +: X_W];
    assign rom_y = rom_data[Y_W-1:0];

    lut_search_arbiter_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .id    (win_id)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = SCAN;
            SCAN:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Equal keys fall through as a miss so the bracket becomes k..k+1.
    always_comb begin
        start = (state_q == IDLE) && (|req);
        hit   = (state_q == SCAN) && (key_q < rom_x);
        last  = (state_q == SCAN) && (rom_addr == ADDR_W'(DEPTH - 1));
        done  = hit || last;
    end

    generate
        if (NREQ > 1) begin : g_ptr
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    ptr_q <= '0;
                else if (start)
                    ptr_q <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
            end
        end else begin : g_no_ptr
            assign ptr_q = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack       <= '0;
            rom_addr  <= '0;
            key_q     <= '0;
            id_q      <= '0;
            prev_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_x0    <= '0;
            rsp_y0    <= '0;
            rsp_x1    <= '0;
            rsp_y1    <= '0;
            rsp_low   <= 1'b0;
            rsp_oor   <= 1'b0;
        end else begin
            ack       <= start ? grant : '0;
            rsp_valid <= done;
            if (start) begin
                key_q    <= key[int'(win_id)*X_W +: X_W];
                id_q     <= win_id;
                rom_addr <= '0;
            end else if ((state_q == SCAN) && !done) begin
                prev_q   <= rom_data;
                rom_addr <= rom_addr + ADDR_W'(1);
            end
            if (done) begin
                rsp_id  <= id_q;
                rsp_low <= hit && (rom_addr == '0);
                rsp_oor <= !hit;
                rsp_x1  <= rom_x;
                rsp_y1  <= rom_y;
                // Both brackets collapse onto the current entry at either table edge.
                if (hit && (rom_addr != '0)) begin
                    rsp_x0 <= prev_q[Y_W +: X_W];
                    rsp_y0 <= prev_q[Y_W-1:0];
                end else begin
                    rsp_x0 <= rom_x;
                    rsp_y0 <= rom_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_search_arbiter.sv
// Directed bench: table X = 10*(i+1), Y = i, two requesters.
module tb_lut_search_arbiter;

    localparam int NREQ = 2, X_W = 48, Y_W = 48, ADDR_W = 7, DEPTH = 128;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*X_W-1:0] key = '0;
    logic [NREQ-1:0]     ack;
    logic [ADDR_W-1:0]   rom_addr;
    logic [X_W+Y_W-1:0]  rom_data;
    logic                rsp_valid;
    logic [0:0]          rsp_id;
    logic [X_W-1:0]      rsp_x0, rsp_x1;
    logic [Y_W-1:0]      rsp_y0, rsp_y1;
    logic                rsp_low, rsp_oor;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic [X_W+Y_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        x = (X_W'(a) + 48'd1) * 48'd10;
        y = Y_W'(a);
        return {x, y};
    endfunction

    assign rom_data = rom_word(rom_addr);

    lut_search_arbiter #(
        .NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .key(key), .ack(ack),
        .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_x0(rsp_x0), .rsp_y0(rsp_y0), .rsp_x1(rsp_x1),
        .rsp_y1(rsp_y1), .rsp_low(rsp_low), .rsp_oor(rsp_oor)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for any ack, checks it is exactly the expected one-hot and arrives in 1 cycle.
    task automatic wait_ack(input string tag, input int id);
        int cyc = 0;
        do begin tick(); cyc++; end while (ack == '0 && cyc < 300);
        chk({tag, "_ack"}, 64'(ack), 64'(1 << id));
        chk({tag, "_ack_lat"}, 64'(cyc), 64'd1);
        req[id] = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int lat, input int id,
                            input int x0, input int y0, input int x1, input int y1,
                            input bit low, input bit oor);
        int cyc = 0;
        do begin tick(); cyc++; end while (!rsp_valid && cyc < 300);
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_id"},  64'(rsp_id), 64'(id));
        chk({tag, "_x0"},  64'(rsp_x0), 64'(x0));
        chk({tag, "_y0"},  64'(rsp_y0), 64'(y0));
        chk({tag, "_x1"},  64'(rsp_x1), 64'(x1));
        chk({tag, "_y1"},  64'(rsp_y1), 64'(y1));
        chk({tag, "_low"}, 64'(rsp_low), 64'(low));
        chk({tag, "_oor"}, 64'(rsp_oor), 64'(oor));
    endtask

    task automatic issue(input int id, input int k);
        key[id*X_W +: X_W] = X_W'(k);
        req[id] = 1'b1;
    endtask

    initial begin
        bit seen;
        #12;
        chk("rst_ack",   64'(ack), 64'd0);
        chk("rst_addr",  64'(rom_addr), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_x1",    64'(rsp_x1), 64'd0);
        reset_n = 1'b1;
        tick();

        // Simultaneous pair from reset pointer: requester 0 first, then 1 back-to-back.
        issue(0, 15); issue(1, 55);
        wait_ack("p1a", 0);
        wait_rsp("p1a", 2, 0, 10, 0, 20, 1, 0, 0);
        wait_ack("p1b", 1);
        wait_rsp("p1b", 6, 1, 50, 4, 60, 5, 0, 0);
        tick();
        chk("pulse_clr", 64'(rsp_valid), 64'd0);
        chk("hold_x1",   64'(rsp_x1), 64'd60);

        // Basic hit at k=3, latency 4.
        issue(0, 35);
        wait_ack("k35", 0);
        wait_rsp("k35", 4, 0, 30, 2, 40, 3, 0, 0);

        // Pointer now favours requester 1.
        issue(0, 15); issue(1, 55);
        wait_ack("p2a", 1);
        wait_rsp("p2a", 6, 1, 50, 4, 60, 5, 0, 0);
        wait_ack("p2b", 0);
        wait_rsp("p2b", 2, 0, 10, 0, 20, 1, 0, 0);

        issue(0, 5);
        wait_ack("low", 0);
        wait_rsp("low", 1, 0, 10, 0, 10, 0, 1, 0);

        issue(1, 40);
        wait_ack("exact", 1);
        wait_rsp("exact", 5, 1, 40, 3, 50, 4, 0, 0);

        issue(0, 1280);
        wait_ack("oor", 0);
        wait_rsp("oor", 128, 0, 1280, 127, 1280, 127, 0, 1);
        chk("oor_addr", 64'(rom_addr), 64'd127);
        tick(); tick();
        chk("oor_addr_hold", 64'(rom_addr), 64'd127);

        // Reset in the middle of a long scan.
        issue(1, 1000);
        wait_ack("mid", 1);
        repeat (10) tick();
        reset_n = 1'b0;
        #2;
        chk("arst_addr",  64'(rom_addr), 64'd0);
        chk("arst_valid", 64'(rsp_valid), 64'd0);
        chk("arst_x0",    64'(rsp_x0), 64'd0);
        chk("arst_oor",   64'(rsp_oor), 64'd0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (rsp_valid || ack != '0) seen = 1'b1;
        end
        chk("arst_quiet", 64'(seen), 64'd0);

        issue(1, 35);
        wait_ack("post", 1);
        wait_rsp("post", 4, 1, 30, 2, 40, 3, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
